// File: rtl/fir_pkg.sv
// Shared constants, config address map and FSM state type for the fir9
// configuration/sequencing controller.
package fir_pkg;

  localparam int unsigned FIR_TAPS    = 9;
  localparam int unsigned FIR_LAT_CYC = 3;
  localparam int unsigned FIR_XW      = 4;
  localparam int unsigned FIR_TW      = 11;

  localparam logic [3:0] ADDR_THRESH = 4'd9;
  localparam logic [3:0] ADDR_COMMIT = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RUN
  } state_t;

  typedef logic [FIR_TAPS-1:0][FIR_XW-1:0] coef_arr_t;

endpackage

// File: rtl/fir_valid_pipe.sv
// Result-qualification delay line plus saturating fill counter; a result is
// qualified once TAPS accepted samples occupy the filter window.
module fir_valid_pipe
  import fir_pkg::*;
#(
  parameter int unsigned TAPS  = FIR_TAPS,
  parameter int unsigned DEPTH = FIR_LAT_CYC + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic accept,
  output logic out_valid
);

  localparam int unsigned FW = $clog2(TAPS + 1);

  logic [FW-1:0]    fill;
  logic [DEPTH-1:0] pipe;
  logic             qual;

  // fill is the pre-increment count, so the TAPS-th accepted sample qualifies
  assign qual = accept && (fill >= FW'(TAPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
      pipe <= '0;
    end else if (clr) begin
      fill <= '0;
      pipe <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], qual};
      if (accept && (fill != FW'(TAPS))) begin
        fill <= fill + 1'b1;
      end
    end
  end

  assign out_valid = pipe[DEPTH-1];

endmodule

// File: rtl/fir_cfg_ctrl.sv
// Config bank, commit/flush sequencing and output qualification for fir9.
// Optional sticky illegal-write flag enabled by FIR_CFG_CTRL_ERR_EN.
module fir_cfg_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned TAPS    = FIR_TAPS,
  parameter int unsigned FIR_LAT = FIR_LAT_CYC,
  parameter int unsigned XW      = FIR_XW,
  parameter int unsigned TW      = FIR_TW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [3:0]         cfg_addr,
  input  logic [TW-1:0]      cfg_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [XW-1:0]      s_data,
  output logic [XW-1:0]      fir_x,
  output logic [TAPS*XW-1:0] fir_c,
  output logic [TW-1:0]      fir_thresh,
  input  logic               fir_y,
  output logic               y_valid,
  output logic               y,
  output logic               busy,
  output logic               cfg_err
);

  localparam int unsigned FLUSH_LEN = TAPS + FIR_LAT;
  localparam int unsigned FCW       = $clog2(FLUSH_LEN);

  state_t                  state, state_nx;
  logic [FCW-1:0]          flush_cnt;
  logic [TAPS-1:0][XW-1:0] shadow_c;
  logic [TAPS-1:0][XW-1:0] active_c;
  logic [TW-1:0]           shadow_t;
  logic                    cfg_fire;
  logic                    commit;
  logic                    accept;
  logic                    flush_done;

  assign cfg_fire   = cfg_valid && cfg_ready;
  assign commit     = cfg_fire && (cfg_addr == ADDR_COMMIT);
  assign accept     = s_valid && s_ready;
  assign flush_done = (flush_cnt == FCW'(FLUSH_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (commit) state_nx = FLUSH;
      FLUSH:   if (flush_done) state_nx = RUN;
      RUN:     if (commit) state_nx = FLUSH;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b1;
    s_ready   = 1'b0;
    busy      = 1'b0;
    case (state)
      FLUSH: begin
        cfg_ready = 1'b0;
        busy      = 1'b1;
      end
      RUN:     s_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if ((state == FLUSH) && !flush_done) begin
      flush_cnt <= flush_cnt + 1'b1;
    end else begin
      flush_cnt <= '0;
    end
  end

  // Shadow writes and commit are mutually exclusive by address, so the commit
  // always copies the shadow contents as they stood before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_c   <= '0;
      shadow_t   <= '0;
      active_c   <= '0;
      fir_thresh <= '0;
    end else if (cfg_fire) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        if (cfg_addr == 4'(i)) shadow_c[i] <= cfg_data[XW-1:0];
      end
      if (cfg_addr == ADDR_THRESH) shadow_t <= cfg_data;
      if (commit) begin
        active_c   <= shadow_c;
        fir_thresh <= shadow_t;
      end
    end
  end

  assign fir_c = active_c;

  // The filter shifts every clock: bubbles and non-RUN cycles feed zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_x <= '0;
    end else if (accept) begin
      fir_x <= s_data;
    end else begin
      fir_x <= '0;
    end
  end

  fir_valid_pipe #(
    .TAPS  (TAPS),
    .DEPTH (FIR_LAT + 1)
  ) u_valid_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (commit),
    .accept    (accept),
    .out_valid (y_valid)
  );

  assign y = fir_y && y_valid;

`ifdef FIR_CFG_CTRL_ERR_EN
  logic bad_addr;
  logic oversize;

  assign bad_addr = cfg_fire && (cfg_addr > ADDR_THRESH) && (cfg_addr != ADDR_COMMIT);
  assign oversize = cfg_fire && (cfg_addr < 4'(TAPS)) && (cfg_data[TW-1:XW] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (bad_addr || oversize) begin
      cfg_err <= 1'b1;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Directed bench for fir_cfg_ctrl with a behavioural 9-tap, 3-cycle filter
// closing the loop on fir_x/fir_c/fir_thresh -> fir_y.
module tb_fir_cfg_ctrl;

  localparam int unsigned TAPS = 9;
  localparam int unsigned XW   = 4;
  localparam int unsigned TW   = 11;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [3:0]         cfg_addr;
  logic [TW-1:0]      cfg_data;
  logic               s_valid;
  logic               s_ready;
  logic [XW-1:0]      s_data;
  logic [XW-1:0]      fir_x;
  logic [TAPS*XW-1:0] fir_c;
  logic [TW-1:0]      fir_thresh;
  logic               fir_y;
  logic               y_valid;
  logic               y;
  logic               busy;
  logic               cfg_err;

  int checks   = 0;
  int failures = 0;

  fir_cfg_ctrl #(
    .TAPS    (TAPS),
    .FIR_LAT (3),
    .XW      (XW),
    .TW      (TW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .fir_x      (fir_x),
    .fir_c      (fir_c),
    .fir_thresh (fir_thresh),
    .fir_y      (fir_y),
    .y_valid    (y_valid),
    .y          (y),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  // Filter model: window of the last 9 fir_x values, result 3 cycles later.
  logic [XW-1:0] hist [TAPS];
  logic          cmp, r1, r2;
  int unsigned   acc;

  initial begin
    for (int i = 0; i < TAPS; i++) hist[i] = '0;
    r1 = 1'b0;
    r2 = 1'b0;
  end

  always_comb begin
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      acc = acc + 32'(fir_c[i*XW +: XW]) * 32'(hist[i]);
    end
    cmp = (acc > 32'(fir_thresh));
  end

  always @(posedge clk) begin
    for (int i = TAPS - 1; i > 0; i--) hist[i] <= hist[i-1];
    hist[0] <= fir_x;
    r1      <= cmp;
    r2      <= r1;
  end

  assign fir_y = r2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [TW-1:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Called in the first FLUSH cycle; returns in the first cycle after it.
  task automatic wait_flush(output int n_busy, output int n_nrdy, output int yv_seen);
    n_busy  = 0;
    n_nrdy  = 0;
    yv_seen = 0;
    while ((busy || !cfg_ready) && (n_busy < 40)) begin
      if (busy) n_busy++;
      if (!cfg_ready) n_nrdy++;
      if (y_valid) yv_seen++;
      tick();
    end
  endtask

  logic       sv [16];
  logic [3:0] sd [16];
  logic       ev [16];
  logic       ey [16];

  task automatic run_stream(input int n);
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) begin
        s_valid = sv[i];
        s_data  = sd[i];
      end else begin
        s_valid = 1'b0;
        s_data  = '0;
      end
      tick();
      if (i < n) check($sformatf("fir_x[%0d]", i), 64'(fir_x), 64'(sv[i] ? sd[i] : 4'd0));
      if (i >= 3) begin
        check($sformatf("y_valid[%0d]", i - 3), 64'(y_valid), 64'(ev[i-3]));
        check($sformatf("y[%0d]", i - 3), 64'(y), 64'(ey[i-3]));
      end
    end
    s_valid = 1'b0;
  endtask

  int nb, nr, yvs;

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    s_valid   = 1'b1;
    s_data    = 4'd5;

    // Reset state
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_fir_x", 64'(fir_x), 64'd0);
    check("rst_fir_c", 64'(fir_c), 64'd0);
    check("rst_thresh", 64'(fir_thresh), 64'd0);
    check("rst_y_valid", 64'(y_valid), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    #9 rst_n = 1'b1;
    tick();
    check("idle_s_ready", 64'(s_ready), 64'd0);
    check("idle_fir_x", 64'(fir_x), 64'd0);
    check("idle_cfg_ready", 64'(cfg_ready), 64'd1);
    s_valid = 1'b0;

    // Load all-ones coefficients, threshold 20, commit
    for (int i = 0; i < 9; i++) cfg_write(4'(i), 11'd1);
    cfg_write(4'd9, 11'd20);
    check("shadow_not_active", 64'(fir_c), 64'd0);
    cfg_write(4'd15, 11'd0);
    check("commit_busy", 64'(busy), 64'd1);
    check("commit_fir_c", 64'(fir_c), 64'h1_1111_1111);
    check("commit_thresh", 64'(fir_thresh), 64'd20);
    wait_flush(nb, nr, yvs);
    check("flush1_len", 64'(nb), 64'd12);
    check("run_s_ready", 64'(s_ready), 64'd1);

    // Fill, post-fill zero, bubble, then window sums 21/21/18
    sv = '{1,1,1,1,1,1,1,1,1,1,0,1,1,1,0,0};
    sd = '{3,3,3,3,3,3,3,3,3,0,7,3,3,0,0,0};
    ev = '{0,0,0,0,0,0,0,0,1,1,0,1,1,1,0,0};
    ey = '{0,0,0,0,0,0,0,0,1,1,0,1,1,0,0,0};
    run_stream(14);

    // Threshold update plus commit with samples in flight
    s_valid = 1'b1;
    s_data  = 4'd3;
    tick();
    tick();
    tick();
    cfg_valid = 1'b1;
    cfg_addr  = 4'd9;
    cfg_data  = 11'd30;
    tick();
    check("yv_before_commit", 64'(y_valid), 64'd1);
    check("thresh_held", 64'(fir_thresh), 64'd20);
    cfg_addr = 4'd15;
    tick();
    cfg_valid = 1'b0;
    s_valid   = 1'b0;
    check("yv_drop", 64'(y_valid), 64'd0);
    check("mid_commit_busy", 64'(busy), 64'd1);
    wait_flush(nb, nr, yvs);
    check("flush2_len", 64'(nb), 64'd12);
    check("flush2_nrdy", 64'(nr), 64'd12);
    check("flush2_yv", 64'(yvs), 64'd0);
    check("thresh_30", 64'(fir_thresh), 64'd30);

    sv = '{1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0};
    sd = '{3,3,3,3,3,3,3,3,3,0,0,0,0,0,0,0};
    ev = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0};
    ey = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    run_stream(9);

    // Illegal address and oversize coefficient
    cfg_write(4'd12, 11'd5);
`ifdef FIR_CFG_CTRL_ERR_EN
    check("cfg_err_set", 64'(cfg_err), 64'd1);
`else
    check("cfg_err_tied", 64'(cfg_err), 64'd0);
`endif
    cfg_write(4'd0, 11'h013);
    cfg_write(4'd15, 11'd0);
    check("oversize_fir_c", 64'(fir_c), 64'h1_1111_1113);
    check("illegal_thresh", 64'(fir_thresh), 64'd30);
    wait_flush(nb, nr, yvs);
    check("flush3_len", 64'(nb), 64'd12);

    // Reset at flush cycle 5
    cfg_write(4'd15, 11'd0);
    for (int i = 0; i < 4; i++) tick();
    check("flush_c5_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_fir_c", 64'(fir_c), 64'd0);
    check("mid_rst_thresh", 64'(fir_thresh), 64'd0);
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    check("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("mid_rst_cfg_err", 64'(cfg_err), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle", 64'(busy), 64'd0);
    cfg_write(4'd15, 11'd0);
    check("recommit_fir_c", 64'(fir_c), 64'd0);
    wait_flush(nb, nr, yvs);
    check("flush4_len", 64'(nb), 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
